// File: rtl/mem_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter_if
//  Purpose  : Bundles the I-cache, D-cache and SDRAM-controller handshakes of
//             the two-port memory arbiter.
//  Revision : 1.0  initial release
// ============================================================================
interface mem_arbiter_if;
    logic [31:0] i_addr;
    logic [31:0] i_data;
    logic        i_we;
    logic        i_start;
    logic [31:0] i_q;
    logic        i_done;

    logic [31:0] d_addr;
    logic [31:0] d_data;
    logic        d_we;
    logic        d_start;
    logic [31:0] d_q;
    logic        d_done;

    logic [31:0] sdc_addr;
    logic [31:0] sdc_data;
    logic        sdc_we;
    logic        sdc_start;
    logic [31:0] sdc_q;
    logic        sdc_done;

    // Arbiter view: serves both caches and masters the SDRAM controller.
    modport master (
        input  i_addr, i_data, i_we, i_start,
        output i_q, i_done,
        input  d_addr, d_data, d_we, d_start,
        output d_q, d_done,
        output sdc_addr, sdc_data, sdc_we, sdc_start,
        input  sdc_q, sdc_done
    );

    // Environment view: the caches and the SDRAM controller.
    modport slave (
        output i_addr, i_data, i_we, i_start,
        input  i_q, i_done,
        output d_addr, d_data, d_we, d_start,
        input  d_q, d_done,
        input  sdc_addr, sdc_data, sdc_we, sdc_start,
        output sdc_q, sdc_done
    );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter
//  Purpose  : Two-port (I-cache / D-cache) arbiter in front of one SDRAM
//             controller; round-robin or fixed D-priority arbitration.
//  Revision : 1.0  initial release
// ============================================================================
module mem_arbiter #(
    parameter int FIXED_PRIO = 0
) (
    input  wire logic          clk,
    input  wire logic          reset,
    mem_arbiter_if.master      bus
);

    localparam bit c_fixed = (FIXED_PRIO != 0);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t r_state;
    logic   r_i_prev, r_d_prev;
    logic   r_i_arm,  r_d_arm;
    logic   r_i_pend, r_d_pend;
    logic   r_last_d;
    logic   r_grant_d;

    logic w_i_rise, w_d_rise;
    logic w_i_req,  w_d_req;
    logic w_pick_d;
    logic w_grant;
    logic w_busy;

    // A port is armed only once its start has been seen low, so a start held
    // high across reset is not mistaken for a fresh request.
    assign w_i_rise = bus.i_start & ~r_i_prev & r_i_arm;
    assign w_d_rise = bus.d_start & ~r_d_prev & r_d_arm;

    // Live request: pending (or rising now) and not withdrawn this cycle.
    assign w_i_req  = bus.i_start & (r_i_pend | w_i_rise);
    assign w_d_req  = bus.d_start & (r_d_pend | w_d_rise);

    assign w_pick_d = w_d_req & (~w_i_req | c_fixed | ~r_last_d);
    assign w_grant  = (r_state == IDLE) & (w_i_req | w_d_req);
    assign w_busy   = (r_state == BUSY);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_i_prev     <= 1'b0;
            r_d_prev     <= 1'b0;
            r_i_arm      <= ~bus.i_start;
            r_d_arm      <= ~bus.d_start;
            r_i_pend     <= 1'b0;
            r_d_pend     <= 1'b0;
            r_last_d     <= 1'b0;
            r_grant_d    <= 1'b0;
            bus.sdc_addr  <= '0;
            bus.sdc_data  <= '0;
            bus.sdc_we    <= 1'b0;
            bus.sdc_start <= 1'b0;
        end else begin
            r_i_prev <= bus.i_start;
            r_d_prev <= bus.d_start;
            r_i_arm  <= r_i_arm | ~bus.i_start;
            r_d_arm  <= r_d_arm | ~bus.d_start;
            r_i_pend <= w_i_req & ~(w_grant & ~w_pick_d);
            r_d_pend <= w_d_req & ~(w_grant &  w_pick_d);

            case (r_state)
                IDLE: begin
                    if (w_grant) begin
                        r_grant_d     <= w_pick_d;
                        r_last_d      <= w_pick_d;
                        bus.sdc_addr  <= w_pick_d ? bus.d_addr : bus.i_addr;
                        bus.sdc_data  <= w_pick_d ? bus.d_data : bus.i_data;
                        bus.sdc_we    <= w_pick_d ? bus.d_we   : bus.i_we;
                        bus.sdc_start <= 1'b1;
                        r_state       <= BUSY;
                    end
                end
                BUSY: begin
                    if (bus.sdc_done) begin
                        bus.sdc_addr  <= '0;
                        bus.sdc_data  <= '0;
                        bus.sdc_we    <= 1'b0;
                        bus.sdc_start <= 1'b0;
                        r_state       <= RELEASE;
                    end
                end
                RELEASE: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // Completion and read data reach the granted requester combinationally.
    assign bus.i_done = bus.sdc_done & w_busy & ~r_grant_d;
    assign bus.d_done = bus.sdc_done & w_busy &  r_grant_d;
    assign bus.i_q    = (w_busy & ~r_grant_d) ? bus.sdc_q : 32'd0;
    assign bus.d_q    = (w_busy &  r_grant_d) ? bus.sdc_q : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_mem_arbiter
//  Purpose  : Directed bench driving a round-robin and a fixed-priority
//             arbiter in lockstep, with a per-instance expected-grant queue.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_arbiter_if bus_rr ();
    mem_arbiter_if bus_fp ();

    mem_arbiter #(.FIXED_PRIO(0)) u_rr (.clk(clk), .reset(reset), .bus(bus_rr.master));
    mem_arbiter #(.FIXED_PRIO(1)) u_fp (.clk(clk), .reset(reset), .bus(bus_fp.master));

    typedef struct {
        logic        port_d;
        logic [31:0] addr;
        logic [31:0] data;
        logic        we;
    } txn_t;

    txn_t exp_rr[$];
    txn_t exp_fp[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic txn_t mk(input logic pd, input logic [31:0] a, input logic [31:0] d, input logic w);
        txn_t t;
        t.port_d = pd; t.addr = a; t.data = d; t.we = w;
        return t;
    endfunction

    task automatic set_i(input logic st, input logic we, input logic [31:0] a, input logic [31:0] d);
        bus_rr.i_start = st; bus_rr.i_we = we; bus_rr.i_addr = a; bus_rr.i_data = d;
        bus_fp.i_start = st; bus_fp.i_we = we; bus_fp.i_addr = a; bus_fp.i_data = d;
    endtask

    task automatic set_d(input logic st, input logic we, input logic [31:0] a, input logic [31:0] d);
        bus_rr.d_start = st; bus_rr.d_we = we; bus_rr.d_addr = a; bus_rr.d_data = d;
        bus_fp.d_start = st; bus_fp.d_we = we; bus_fp.d_addr = a; bus_fp.d_data = d;
    endtask

    task automatic set_sdc(input logic dn, input logic [31:0] q);
        bus_rr.sdc_done = dn; bus_rr.sdc_q = q;
        bus_fp.sdc_done = dn; bus_fp.sdc_q = q;
    endtask

    task automatic chk_issue(input string tag, input logic [31:0] a, input logic [31:0] d, input logic we, input txn_t e);
        chk({tag, "_addr"}, a, e.addr);
        chk({tag, "_data"}, d, e.data);
        chk({tag, "_we"}, {31'd0, we}, {31'd0, e.we});
    endtask

    task automatic chk_done(input string tag, input logic idn, input logic ddn,
                            input logic [31:0] iq, input logic [31:0] dq,
                            input txn_t e, input logic [31:0] rd);
        chk({tag, "_d_done"}, {31'd0, ddn}, {31'd0, e.port_d});
        chk({tag, "_i_done"}, {31'd0, idn}, {31'd0, ~e.port_d});
        chk({tag, "_d_q"}, dq, e.port_d ? rd : 32'd0);
        chk({tag, "_i_q"}, iq, e.port_d ? 32'd0 : rd);
    endtask

    // Controller model: wait for the request, check it against the queue head,
    // answer after lat cycles, then check the release gap.
    task automatic serve(input int lat, input logic [31:0] rd);
        int   n;
        txn_t e_rr, e_fp;
        n = 0;
        while (bus_rr.sdc_start !== 1'b1 && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("grant_rr", {31'd0, bus_rr.sdc_start}, 32'd1);
        chk("grant_fp", {31'd0, bus_fp.sdc_start}, 32'd1);
        chk("sb_rr_nonempty", {31'd0, exp_rr.size() > 0}, 32'd1);
        chk("sb_fp_nonempty", {31'd0, exp_fp.size() > 0}, 32'd1);
        e_rr = (exp_rr.size() > 0) ? exp_rr.pop_front() : mk(1'b0, 32'd0, 32'd0, 1'b0);
        e_fp = (exp_fp.size() > 0) ? exp_fp.pop_front() : mk(1'b0, 32'd0, 32'd0, 1'b0);
        chk_issue("iss_rr", bus_rr.sdc_addr, bus_rr.sdc_data, bus_rr.sdc_we, e_rr);
        chk_issue("iss_fp", bus_fp.sdc_addr, bus_fp.sdc_data, bus_fp.sdc_we, e_fp);
        repeat (lat) @(negedge clk);
        chk_issue("hold_rr", bus_rr.sdc_addr, bus_rr.sdc_data, bus_rr.sdc_we, e_rr);
        chk("hold_start_rr", {31'd0, bus_rr.sdc_start}, 32'd1);
        set_sdc(1'b1, rd);
        #1;
        chk_done("done_rr", bus_rr.i_done, bus_rr.d_done, bus_rr.i_q, bus_rr.d_q, e_rr, rd);
        chk_done("done_fp", bus_fp.i_done, bus_fp.d_done, bus_fp.i_q, bus_fp.d_q, e_fp, rd);
        @(negedge clk);
        set_sdc(1'b0, 32'h0BAD_0BAD);
        chk("post_start_rr", {31'd0, bus_rr.sdc_start}, 32'd0);
        chk("post_addr_rr", bus_rr.sdc_addr, 32'd0);
        chk("post_data_rr", bus_rr.sdc_data, 32'd0);
        @(negedge clk);
        chk("release_gap_rr", {31'd0, bus_rr.sdc_start}, 32'd0);
        chk("release_gap_fp", {31'd0, bus_fp.sdc_start}, 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        set_i(1'b0, 1'b0, 32'd0, 32'd0);
        set_d(1'b0, 1'b0, 32'd0, 32'd0);
        set_sdc(1'b0, 32'h1234_5678);
        repeat (2) @(negedge clk);
        chk("rst_start", {31'd0, bus_rr.sdc_start}, 32'd0);
        chk("rst_addr", bus_rr.sdc_addr, 32'd0);
        chk("rst_data", bus_rr.sdc_data, 32'd0);
        chk("rst_we", {31'd0, bus_rr.sdc_we}, 32'd0);
        chk("rst_i_q", bus_rr.i_q, 32'd0);
        chk("rst_d_q", bus_rr.d_q, 32'd0);
        chk("rst_done", {30'd0, bus_rr.i_done, bus_rr.d_done}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Single read on D with exact cycle latency.
        set_d(1'b1, 1'b0, 32'h0000_0100, 32'd0);
        exp_rr.push_back(mk(1'b1, 32'h100, 32'd0, 1'b0));
        exp_fp.push_back(mk(1'b1, 32'h100, 32'd0, 1'b0));
        @(negedge clk);
        chk("rd_latency", {31'd0, bus_rr.sdc_start}, 32'd1);
        serve(4, 32'hDEAD_BEEF);
        repeat (4) @(negedge clk);
        chk("no_reissue_rr", {31'd0, bus_rr.sdc_start}, 32'd0);
        chk("no_reissue_fp", {31'd0, bus_fp.sdc_start}, 32'd0);
        set_d(1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);

        // Simultaneous with D granted last: RR picks I, fixed picks D.
        set_i(1'b1, 1'b0, 32'h200, 32'd0);
        set_d(1'b1, 1'b0, 32'h300, 32'd0);
        exp_rr.push_back(mk(1'b0, 32'h200, 32'd0, 1'b0));
        exp_rr.push_back(mk(1'b1, 32'h300, 32'd0, 1'b0));
        exp_fp.push_back(mk(1'b1, 32'h300, 32'd0, 1'b0));
        exp_fp.push_back(mk(1'b0, 32'h200, 32'd0, 1'b0));
        @(negedge clk);
        serve(2, 32'hA1A1_0001);
        serve(2, 32'hA2A2_0002);
        set_i(1'b0, 1'b0, 32'd0, 32'd0);
        set_d(1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);

        // Write on I; requester changes address/data while busy.
        set_i(1'b1, 1'b1, 32'h10, 32'h55);
        exp_rr.push_back(mk(1'b0, 32'h10, 32'h55, 1'b1));
        exp_fp.push_back(mk(1'b0, 32'h10, 32'h55, 1'b1));
        @(negedge clk);
        set_i(1'b1, 1'b0, 32'h20, 32'h99);
        serve(3, 32'h5A5A_5A5A);
        set_i(1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);

        // Simultaneous with I granted last: both instances pick D, then I.
        for (int r = 0; r < 2; r++) begin
            set_i(1'b1, 1'b0, 32'h800 + r, 32'd0);
            set_d(1'b1, 1'b1, 32'h900 + r, 32'hF0 + r);
            exp_rr.push_back(mk(1'b1, 32'h900 + r, 32'hF0 + r, 1'b1));
            exp_rr.push_back(mk(1'b0, 32'h800 + r, 32'd0, 1'b0));
            exp_fp.push_back(mk(1'b1, 32'h900 + r, 32'hF0 + r, 1'b1));
            exp_fp.push_back(mk(1'b0, 32'h800 + r, 32'd0, 1'b0));
            @(negedge clk);
            serve(1, 32'hC0DE_0000 + r);
            serve(1, 32'hC0DE_1000 + r);
            set_i(1'b0, 1'b0, 32'd0, 32'd0);
            set_d(1'b0, 1'b0, 32'd0, 32'd0);
            @(negedge clk);
        end

        // I rises while D is busy and is served afterwards.
        set_d(1'b1, 1'b0, 32'hA00, 32'd0);
        exp_rr.push_back(mk(1'b1, 32'hA00, 32'd0, 1'b0));
        exp_fp.push_back(mk(1'b1, 32'hA00, 32'd0, 1'b0));
        exp_rr.push_back(mk(1'b0, 32'hB00, 32'd0, 1'b0));
        exp_fp.push_back(mk(1'b0, 32'hB00, 32'd0, 1'b0));
        @(negedge clk);
        set_i(1'b1, 1'b0, 32'hB00, 32'd0);
        @(negedge clk);
        serve(2, 32'h1111_2222);
        serve(2, 32'h3333_4444);
        set_i(1'b0, 1'b0, 32'd0, 32'd0);
        set_d(1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);

        // Withdrawal of I during D busy; D drops start mid-transaction.
        set_d(1'b1, 1'b0, 32'h400, 32'd0);
        exp_rr.push_back(mk(1'b1, 32'h400, 32'd0, 1'b0));
        exp_fp.push_back(mk(1'b1, 32'h400, 32'd0, 1'b0));
        @(negedge clk);
        set_i(1'b1, 1'b0, 32'h500, 32'd0);
        @(negedge clk);
        set_i(1'b0, 1'b0, 32'h500, 32'd0);
        set_d(1'b0, 1'b0, 32'h400, 32'd0);
        serve(2, 32'h0000_CAFE);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("withdrawn_rr", {31'd0, bus_rr.sdc_start}, 32'd0);
        end

        // sdc_done while idle is ignored.
        set_sdc(1'b1, 32'hFFFF_FFFF);
        #1;
        chk("idle_done", {30'd0, bus_rr.i_done, bus_rr.d_done}, 32'd0);
        chk("idle_q", bus_rr.i_q | bus_rr.d_q, 32'd0);
        @(negedge clk);
        set_sdc(1'b0, 32'd0);
        chk("idle_start", {31'd0, bus_rr.sdc_start}, 32'd0);

        // Reset mid-busy, late sdc_done, held start not served.
        set_i(1'b1, 1'b0, 32'h600, 32'd0);
        @(negedge clk);
        chk("pre_rst_grant", {31'd0, bus_rr.sdc_start}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        set_sdc(1'b1, 32'h0000_0BAD);
        #1;
        chk("late_done_rr", {30'd0, bus_rr.i_done, bus_rr.d_done}, 32'd0);
        chk("late_done_fp", {30'd0, bus_fp.i_done, bus_fp.d_done}, 32'd0);
        chk("late_i_q", bus_rr.i_q, 32'd0);
        chk("rst_busy_start", {31'd0, bus_rr.sdc_start}, 32'd0);
        @(negedge clk);
        set_sdc(1'b0, 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("held_after_rst", {31'd0, bus_rr.sdc_start}, 32'd0);
        end
        set_i(1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        set_i(1'b1, 1'b0, 32'h700, 32'd0);
        exp_rr.push_back(mk(1'b0, 32'h700, 32'd0, 1'b0));
        exp_fp.push_back(mk(1'b0, 32'h700, 32'd0, 1'b0));
        @(negedge clk);
        serve(1, 32'h7777_7777);
        set_i(1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);

        chk("sb_drained", exp_rr.size() + exp_fp.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
